// File: rtl/moving_avg_pkg.sv
// Shared widths and helpers for the moving_avg streaming filter.
package moving_avg_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 4;

   function automatic int unsigned log2_depth(input int unsigned depth);
      return $clog2(depth);
   endfunction

   localparam int unsigned LOG2_DEPTH = log2_depth(DEPTH_DEF);
   localparam int unsigned SUM_W      = DATA_W_DEF + LOG2_DEPTH;
   localparam int unsigned SAMPLE_W   = DATA_W_DEF;
   localparam int unsigned CNT_W      = LOG2_DEPTH + 1;

endpackage

// File: rtl/moving_avg_window.sv
// DEPTH-entry sample shift register; exposes the entry about to drop out and a
// saturating fill counter.
module moving_avg_window
   import moving_avg_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned DEPTH  = DEPTH_DEF,
   localparam int unsigned CW     = log2_depth(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] num,
   output logic signed [DATA_W-1:0] oldest,
   output logic        [CW-1:0]     fill_cnt
);

   logic signed [DATA_W-1:0] win_q [DEPTH];
   logic signed [DATA_W-1:0] win_d [DEPTH];
   logic        [CW-1:0]     fill_q;
   logic        [CW-1:0]     fill_d;

   always_comb begin
      win_d[0] = num;
      for (int i = 1; i < int'(DEPTH); i++) begin
         win_d[i] = win_q[i-1];
      end
      // Saturate at DEPTH so avg_valid stays high until the next reset.
      fill_d = (fill_q == CW'(DEPTH)) ? fill_q : fill_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            win_q[i] <= '0;
         end
         fill_q <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            win_q[i] <= win_d[i];
         end
         fill_q <= fill_d;
      end
   end

   assign oldest   = win_q[DEPTH-1];
   assign fill_cnt = fill_q;

endmodule

// File: rtl/moving_avg.sv
// Streaming moving-average filter: running window sum plus shift-divide.
// Build option MOVING_AVG_ROUND_EN selects round-half-up instead of floor.
module moving_avg
   import moving_avg_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned DEPTH  = DEPTH_DEF,
   localparam int unsigned LW     = log2_depth(DEPTH),
   localparam int unsigned SW     = DATA_W + LW,
   localparam int unsigned CW     = LW + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] num,
   output logic signed [DATA_W-1:0] avg,
   output logic signed [SW-1:0]     sum,
   output logic                     avg_valid
);

   logic signed [DATA_W-1:0] oldest;
   logic        [CW-1:0]     fill_cnt;
   logic signed [SW-1:0]     sum_q;
   logic signed [SW-1:0]     sum_d;
   logic signed [SW-1:0]     num_ext;
   logic signed [SW-1:0]     old_ext;

   moving_avg_window #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_window (
      .clk      (clk),
      .rst      (rst),
      .num      (num),
      .oldest   (oldest),
      .fill_cnt (fill_cnt)
   );

   // SW bits hold DEPTH full-scale samples, so the update cannot overflow.
   always_comb begin
      num_ext = $signed({{LW{num[DATA_W-1]}}, num});
      old_ext = $signed({{LW{oldest[DATA_W-1]}}, oldest});
      sum_d   = sum_q + num_ext - old_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

`ifdef MOVING_AVG_ROUND_EN
   localparam logic signed [DATA_W:0] AVG_MAX = (DATA_W+1)'((2 ** (DATA_W - 1)) - 1);
   logic signed [DATA_W:0] rnd_hi;

   // Adding half an LSB before the shift only carries in bit LW-1 of the sum.
   always_comb begin
      rnd_hi = $signed({sum_q[SW-1], sum_q[SW-1:LW]})
             + $signed({{DATA_W{1'b0}}, sum_q[LW-1]});
      avg    = (rnd_hi > AVG_MAX) ? AVG_MAX[DATA_W-1:0] : rnd_hi[DATA_W-1:0];
   end
`else
   always_comb begin
      avg = sum_q[SW-1:LW];
   end
`endif

   assign sum       = sum_q;
   assign avg_valid = (fill_cnt == CW'(DEPTH));

endmodule

// File: tb/tb_moving_avg.sv
// Scoreboard bench for moving_avg (DEPTH=4, DATA_W=8); follows MOVING_AVG_ROUND_EN.
module tb_moving_avg;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [7:0] num;
   logic signed [7:0] avg;
   logic signed [9:0] sum;
   logic              avg_valid;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int s;
      int a;
      int v;
   } exp_t;

   exp_t exp_q[$];
   int   win[4];
   int   caps;

   moving_avg dut (
      .clk       (clk),
      .rst       (rst),
      .num       (num),
      .avg       (avg),
      .sum       (sum),
      .avg_valid (avg_valid)
   );

   always #25 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int model_avg(input int s);
      int r;
`ifdef MOVING_AVG_ROUND_EN
      r = $floor((real'(s) + 2.0) / 4.0);
      if (r > 127) r = 127;
`else
      r = $floor(real'(s) / 4.0);
`endif
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) win[i] = 0;
      caps = 0;
   endtask

   // Drive one sample, predict outputs after the edge, compare once it has passed.
   task automatic drive(input int v, input string tag);
      exp_t e;
      exp_t got;
      num = 8'(v);
      for (int i = 3; i > 0; i--) win[i] = win[i-1];
      win[0] = v;
      if (caps < 4) caps++;
      e.s = win[0] + win[1] + win[2] + win[3];
      e.a = model_avg(e.s);
      e.v = (caps == 4) ? 1 : 0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(got.s));
      check({tag, "_avg"}, 32'(avg), 32'(got.a));
      check({tag, "_vld"}, 32'(avg_valid), 32'(got.v));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      num = 8'sd55;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum", 32'(sum), 0);
      check("rst_avg", 32'(avg), 0);
      check("rst_vld", 32'(avg_valid), 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      num = -8'sd7;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("init_sum", 32'(sum), 0);
      check("init_avg", 32'(avg), 0);
      check("init_vld", 32'(avg_valid), 0);
      rst = 1'b0;

      // Small mixed-sign sequence
      drive(2, "seq"); drive(1, "seq"); drive(-1, "seq"); drive(0, "seq");

      // Step up then step down
      do_reset();
      for (int i = 0; i < 4; i++) drive(8, "up");
      for (int i = 0; i < 4; i++) drive(0, "down");

      // Single -1 impulse exposes floor vs round
      do_reset();
      drive(-1, "imp");
      for (int i = 0; i < 5; i++) drive(0, "imp");

      // Full-scale extremes
      for (int i = 0; i < 4; i++) drive(127, "max");
      for (int i = 0; i < 4; i++) drive(-128, "min");

      // Random stream
      for (int i = 0; i < 40; i++) drive(int'($urandom_range(255)) - 128, "rnd");

      // Asynchronous reset between edges with a full window
      for (int i = 0; i < 4; i++) drive(100, "pre");
      #10;
      rst = 1'b1;
      #1;
      check("async_sum", 32'(sum), 0);
      check("async_avg", 32'(avg), 0);
      check("async_vld", 32'(avg_valid), 0);
      #5;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) drive(20 - 10 * i, "refill");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
